rdma_req_split: RTL and testbench

Splits user RDMA commands of arbitrary length into a sequence of bounded-size RDMA requests. It sits directly upstream of the RDMA flow-control stage and drives that stage's request input. Every emitted request carries the command's SSN. The `last` flag marks the final chunk, so the flow stage enqueues exactly one user ack per command. `cmplt` is propagated on the final chunk only.

---
 rtl/rdma_req_split.sv | 146 ++++++++++++++
 tb/tb_rdma_req_split.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rdma_req_split.sv
// Splits user RDMA commands into requests of at most 2^CHUNK_BITS bytes; first chunk 1 cycle after accept; outputs held while m_req_ready is low.
// Defining RDMA_SPLIT_ALIGN_EN cuts chunks on 2^CHUNK_BITS boundaries of the remote address.
module rdma_req_split #(
    parameter int CHUNK_BITS = 20,
    parameter int LEN_BITS   = 32,
    parameter int QPN_BITS   = 24,
    parameter int SSN_BITS   = 24
) (
    input  logic                aclk,
    input  logic                aresetn,
    input  logic                s_cmd_valid,
    output logic                s_cmd_ready,
    input  logic [4:0]          s_cmd_opcode,
    input  logic [QPN_BITS-1:0] s_cmd_qpn,
    input  logic [63:0]         s_cmd_laddr,
    input  logic [63:0]         s_cmd_raddr,
    input  logic [LEN_BITS-1:0] s_cmd_len,
    input  logic [SSN_BITS-1:0] s_cmd_ssn,
    input  logic                s_cmd_cmplt,
    output logic                m_req_valid,
    input  logic                m_req_ready,
    output logic [4:0]          m_req_opcode,
    output logic [QPN_BITS-1:0] m_req_qpn,
    output logic [SSN_BITS-1:0] m_req_ssn,
    output logic [63:0]         m_req_laddr,
    output logic [63:0]         m_req_raddr,
    output logic [LEN_BITS-1:0] m_req_len,
    output logic                m_req_last,
    output logic                m_req_cmplt
);
    typedef enum logic {IDLE, SPLIT} state_t;

    localparam logic [LEN_BITS-1:0] CHUNK_MAX = LEN_BITS'(1) << CHUNK_BITS;

    state_t              state, state_nxt;
    logic [LEN_BITS-1:0] rem_q;
    logic [63:0]         laddr_q, raddr_q;
    logic [4:0]          opcode_q;
    logic [QPN_BITS-1:0] qpn_q;
    logic [SSN_BITS-1:0] ssn_q;
    logic                cmplt_q;

    logic                free, load;
    logic [LEN_BITS-1:0] cur_len, limit, clen, rem_nxt;
    logic [63:0]         cur_laddr, cur_raddr;
    logic [4:0]          cur_opcode;
    logic [QPN_BITS-1:0] cur_qpn;
    logic [SSN_BITS-1:0] cur_ssn;
    logic                cur_cmplt;

    assign free        = !m_req_valid || m_req_ready;
    assign s_cmd_ready = aresetn && (state == IDLE) && free;

    // In IDLE the chunk is cut straight from the incoming command, in SPLIT from the stored remainder.
    always_comb begin
        if (state == IDLE) begin
            cur_len    = s_cmd_len;
            cur_laddr  = s_cmd_laddr;
            cur_raddr  = s_cmd_raddr;
            cur_opcode = s_cmd_opcode;
            cur_qpn    = s_cmd_qpn;
            cur_ssn    = s_cmd_ssn;
            cur_cmplt  = s_cmd_cmplt;
        end else begin
            cur_len    = rem_q;
            cur_laddr  = laddr_q;
            cur_raddr  = raddr_q;
            cur_opcode = opcode_q;
            cur_qpn    = qpn_q;
            cur_ssn    = ssn_q;
            cur_cmplt  = cmplt_q;
        end
`ifdef RDMA_SPLIT_ALIGN_EN
        limit = CHUNK_MAX - LEN_BITS'(cur_raddr[CHUNK_BITS-1:0]);
`else
        limit = CHUNK_MAX;
`endif
        clen    = (cur_len < limit) ? cur_len : limit;
        rem_nxt = cur_len - clen;
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        case (state)
            IDLE: begin
                load = s_cmd_valid && s_cmd_ready;
                if (load && rem_nxt != '0)
                    state_nxt = SPLIT;
            end
            SPLIT: begin
                load = free;
                if (load && rem_nxt == '0)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            m_req_valid  <= 1'b0;
            m_req_opcode <= '0;
            m_req_qpn    <= '0;
            m_req_ssn    <= '0;
            m_req_laddr  <= '0;
            m_req_raddr  <= '0;
            m_req_len    <= '0;
            m_req_last   <= 1'b0;
            m_req_cmplt  <= 1'b0;
            rem_q        <= '0;
            laddr_q      <= '0;
            raddr_q      <= '0;
            opcode_q     <= '0;
            qpn_q        <= '0;
            ssn_q        <= '0;
            cmplt_q      <= 1'b0;
        end else if (load) begin
            m_req_valid  <= 1'b1;
            m_req_opcode <= cur_opcode;
            m_req_qpn    <= cur_qpn;
            m_req_ssn    <= cur_ssn;
            m_req_laddr  <= cur_laddr;
            m_req_raddr  <= cur_raddr;
            m_req_len    <= clen;
            m_req_last   <= (rem_nxt == '0);
            m_req_cmplt  <= (rem_nxt == '0) && cur_cmplt;
            rem_q        <= rem_nxt;
            laddr_q      <= cur_laddr + 64'(clen);
            raddr_q      <= cur_raddr + 64'(clen);
            opcode_q     <= cur_opcode;
            qpn_q        <= cur_qpn;
            ssn_q        <= cur_ssn;
            cmplt_q      <= cur_cmplt;
        end else if (m_req_ready) begin
            m_req_valid  <= 1'b0;
        end
    end
endmodule

// File: tb/tb_rdma_req_split.sv
// Randomised and directed bench for rdma_req_split (CHUNK_BITS=12) against a queue-based chunking model.
module tb_rdma_req_split;
    localparam int CB = 12;
    localparam logic [63:0] CSZ = 64'd4096;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        s_cmd_valid = 1'b0;
    logic        s_cmd_ready;
    logic [4:0]  s_cmd_opcode = '0;
    logic [23:0] s_cmd_qpn = '0;
    logic [63:0] s_cmd_laddr = '0;
    logic [63:0] s_cmd_raddr = '0;
    logic [31:0] s_cmd_len = '0;
    logic [23:0] s_cmd_ssn = '0;
    logic        s_cmd_cmplt = 1'b0;
    logic        m_req_valid;
    logic        m_req_ready = 1'b0;
    logic [4:0]  m_req_opcode;
    logic [23:0] m_req_qpn;
    logic [23:0] m_req_ssn;
    logic [63:0] m_req_laddr;
    logic [63:0] m_req_raddr;
    logic [31:0] m_req_len;
    logic        m_req_last;
    logic        m_req_cmplt;

    rdma_req_split #(.CHUNK_BITS(CB), .LEN_BITS(32), .QPN_BITS(24), .SSN_BITS(24)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_cmd_valid(s_cmd_valid), .s_cmd_ready(s_cmd_ready), .s_cmd_opcode(s_cmd_opcode),
        .s_cmd_qpn(s_cmd_qpn), .s_cmd_laddr(s_cmd_laddr), .s_cmd_raddr(s_cmd_raddr),
        .s_cmd_len(s_cmd_len), .s_cmd_ssn(s_cmd_ssn), .s_cmd_cmplt(s_cmd_cmplt),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_opcode(m_req_opcode),
        .m_req_qpn(m_req_qpn), .m_req_ssn(m_req_ssn), .m_req_laddr(m_req_laddr),
        .m_req_raddr(m_req_raddr), .m_req_len(m_req_len), .m_req_last(m_req_last),
        .m_req_cmplt(m_req_cmplt)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [4:0]  opcode;
        logic [23:0] qpn;
        logic [23:0] ssn;
        logic [63:0] laddr;
        logic [63:0] raddr;
        logic [31:0] len;
        logic        last;
        logic        cmplt;
        int          cyc;
    } beat_t;

    beat_t exp_q[$];
    beat_t obs_q[$];
    beat_t mon_b;
    int    tests = 0;
    int    fails = 0;
    int    cyc = 0;
    logic  rand_rdy = 1'b0;

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        if (aresetn && m_req_valid && m_req_ready) begin
            mon_b.opcode = m_req_opcode; mon_b.qpn = m_req_qpn; mon_b.ssn = m_req_ssn;
            mon_b.laddr = m_req_laddr; mon_b.raddr = m_req_raddr; mon_b.len = m_req_len;
            mon_b.last = m_req_last; mon_b.cmplt = m_req_cmplt; mon_b.cyc = cyc;
            obs_q.push_back(mon_b);
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #2;
            if (rand_rdy) m_req_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    // Reference: a command becomes a list of chunks, each the smaller of what remains and the
    // distance to the next chunk limit; the last chunk carries the completion flag.
    task automatic model_cmd(input logic [4:0] op, input logic [23:0] qpn, input logic [63:0] la,
                             input logic [63:0] ra, input logic [31:0] len, input logic [23:0] ssn,
                             input logic cm);
        logic [63:0] rem, lim, c;
        beat_t b;
        rem = 64'(len);
        do begin
            lim = CSZ;
`ifdef RDMA_SPLIT_ALIGN_EN
            lim = CSZ - (ra % CSZ);
`endif
            c = (rem < lim) ? rem : lim;
            rem = rem - c;
            b.opcode = op; b.qpn = qpn; b.ssn = ssn; b.laddr = la; b.raddr = ra;
            b.len = 32'(c); b.last = (rem == 0); b.cmplt = (rem == 0) ? cm : 1'b0; b.cyc = 0;
            exp_q.push_back(b);
            la = la + c;
            ra = ra + c;
        end while (rem != 0);
    endtask

    task automatic send_cmd(input logic [4:0] op, input logic [23:0] qpn, input logic [63:0] la,
                            input logic [63:0] ra, input logic [31:0] len, input logic [23:0] ssn,
                            input logic cm, output int acc, output int waited);
        s_cmd_opcode = op; s_cmd_qpn = qpn; s_cmd_laddr = la; s_cmd_raddr = ra;
        s_cmd_len = len; s_cmd_ssn = ssn; s_cmd_cmplt = cm; s_cmd_valid = 1'b1;
        model_cmd(op, qpn, la, ra, len, ssn, cm);
        waited = 0;
        acc = -1;
        @(negedge aclk);
        while (!s_cmd_ready && waited < 500) begin
            @(negedge aclk);
            waited++;
        end
        if (!s_cmd_ready) begin
            tests++; fails++;
            $display("FAIL cmd_accept_timeout: s_cmd_ready=%b after %0d cycles, required 1", s_cmd_ready, waited);
        end else begin
            acc = cyc;
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic check_flush(input string name);
        int n;
        n = 0;
        while (obs_q.size() < exp_q.size() && n < 3000) begin
            @(negedge aclk);
            n++;
        end
        repeat (6) @(negedge aclk);
        tests++;
        if (obs_q.size() !== exp_q.size()) begin
            fails++;
            $display("FAIL %s_count: got %0d requests, required %0d", name, obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            tests++;
            if (obs_q[i].opcode !== exp_q[i].opcode || obs_q[i].qpn !== exp_q[i].qpn ||
                obs_q[i].ssn !== exp_q[i].ssn || obs_q[i].laddr !== exp_q[i].laddr ||
                obs_q[i].raddr !== exp_q[i].raddr || obs_q[i].len !== exp_q[i].len ||
                obs_q[i].last !== exp_q[i].last || obs_q[i].cmplt !== exp_q[i].cmplt) begin
                fails++;
                $display("FAIL %s_req%0d: got len=%0d la=%h ra=%h last=%b cmplt=%b ssn=%h qpn=%h op=%h, required len=%0d la=%h ra=%h last=%b cmplt=%b ssn=%h qpn=%h op=%h",
                         name, i, obs_q[i].len, obs_q[i].laddr, obs_q[i].raddr, obs_q[i].last, obs_q[i].cmplt,
                         obs_q[i].ssn, obs_q[i].qpn, obs_q[i].opcode, exp_q[i].len, exp_q[i].laddr,
                         exp_q[i].raddr, exp_q[i].last, exp_q[i].cmplt, exp_q[i].ssn, exp_q[i].qpn, exp_q[i].opcode);
            end
        end
    endtask

    task automatic clear_q();
        exp_q.delete();
        obs_q.delete();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        @(negedge aclk);
        tests++;
        if (s_cmd_ready !== 1'b0 || m_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_hs: s_cmd_ready=%b m_req_valid=%b, required 0 0", s_cmd_ready, m_req_valid);
        end
        tests++;
        if (m_req_len !== 32'd0 || m_req_laddr !== 64'd0 || m_req_raddr !== 64'd0 || m_req_last !== 1'b0 ||
            m_req_cmplt !== 1'b0 || m_req_ssn !== 24'd0 || m_req_qpn !== 24'd0 || m_req_opcode !== 5'd0) begin
            fails++;
            $display("FAIL reset_fields: len=%0d la=%h ra=%h last=%b cmplt=%b, required all 0",
                     m_req_len, m_req_laddr, m_req_raddr, m_req_last, m_req_cmplt);
        end
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        tests++;
        if (s_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: s_cmd_ready=%b, required 1", s_cmd_ready);
        end
        @(posedge aclk);
        #1;
    endtask

    task automatic test_split_10000();
        int acc, w;
        logic [31:0] el [3] = '{32'd4096, 32'd4096, 32'd1808};
        logic [63:0] ela [3] = '{64'h2000, 64'h3000, 64'h4000};
        logic [63:0] era [3] = '{64'h1000, 64'h2000, 64'h3000};
        logic        elast [3] = '{1'b0, 1'b0, 1'b1};
        m_req_ready = 1'b1;
        send_cmd(5'h0a, 24'h000123, 64'h2000, 64'h1000, 32'd10000, 24'd7, 1'b1, acc, w);
        s_cmd_valid = 1'b0;
        check_flush("split10000");
        if (obs_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (obs_q[i].len !== el[i] || obs_q[i].laddr !== ela[i] || obs_q[i].raddr !== era[i] ||
                    obs_q[i].last !== elast[i] || obs_q[i].cmplt !== elast[i] || obs_q[i].ssn !== 24'd7 ||
                    obs_q[i].cyc !== obs_q[0].cyc + i) begin
                    fails++;
                    $display("FAIL plan10000_chunk%0d: got len=%0d la=%h ra=%h last=%b cmplt=%b ssn=%0d cyc+%0d, required len=%0d la=%h ra=%h last=%b cmplt=%b ssn=7 cyc+%0d",
                             i, obs_q[i].len, obs_q[i].laddr, obs_q[i].raddr, obs_q[i].last, obs_q[i].cmplt,
                             obs_q[i].ssn, obs_q[i].cyc - obs_q[0].cyc, el[i], ela[i], era[i], elast[i], elast[i], i);
                end
            end
            tests++;
            if (obs_q[0].cyc !== acc + 1) begin
                fails++;
                $display("FAIL first_latency: first chunk in cycle %0d, required %0d", obs_q[0].cyc, acc + 1);
            end
        end
        clear_q();
    endtask

    task automatic test_exact_and_zero();
        int acc, w;
        m_req_ready = 1'b1;
        send_cmd(5'h04, 24'h000042, 64'h7000, 64'h10000, 32'd8192, 24'd9, 1'b1, acc, w);
        s_cmd_valid = 1'b0;
        check_flush("exact8192");
        tests++;
        if (obs_q.size() !== 2) begin
            fails++;
            $display("FAIL exact8192_no_tail: got %0d requests, required 2", obs_q.size());
        end
        clear_q();
        send_cmd(5'h06, 24'h000043, 64'h1234, 64'h5678, 32'd0, 24'd10, 1'b1, acc, w);
        s_cmd_valid = 1'b0;
        check_flush("zero_len");
        tests++;
        if (obs_q.size() !== 1 || (obs_q.size() == 1 && (obs_q[0].len !== 32'd0 || obs_q[0].last !== 1'b1))) begin
            fails++;
            $display("FAIL zero_len_single: got %0d requests, required 1 with len=0 last=1", obs_q.size());
        end
        clear_q();
    endtask

`ifdef RDMA_SPLIT_ALIGN_EN
    task automatic test_align();
        int acc, w;
        logic [31:0] el [3] = '{32'd256, 32'd4096, 32'd648};
        logic [63:0] era [3] = '{64'h1F00, 64'h2000, 64'h3000};
        m_req_ready = 1'b1;
        send_cmd(5'h0a, 24'h000055, 64'h8000, 64'h1F00, 32'd5000, 24'd11, 1'b0, acc, w);
        s_cmd_valid = 1'b0;
        check_flush("align5000");
        if (obs_q.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                tests++;
                if (obs_q[i].len !== el[i] || obs_q[i].raddr !== era[i]) begin
                    fails++;
                    $display("FAIL align_chunk%0d: got len=%0d ra=%h, required len=%0d ra=%h",
                             i, obs_q[i].len, obs_q[i].raddr, el[i], era[i]);
                end
            end
        end
        clear_q();
    endtask
`endif

    task automatic test_backpressure();
        int acc, w;
        m_req_ready = 1'b1;
        send_cmd(5'h0b, 24'h000077, 64'h5000, 64'h9000, 32'd10000, 24'd12, 1'b1, acc, w);
        s_cmd_valid = 1'b0;
        @(posedge aclk);
        #1;
        m_req_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            tests++;
            if (m_req_valid !== 1'b1 || m_req_len !== 32'd4096 || m_req_laddr !== 64'h6000 ||
                m_req_raddr !== 64'hA000 || m_req_last !== 1'b0 || m_req_ssn !== 24'd12 || s_cmd_ready !== 1'b0) begin
                fails++;
                $display("FAIL bp_hold%0d: valid=%b len=%0d la=%h ra=%h last=%b s_cmd_ready=%b, required 1 4096 6000 a000 0 0",
                         i, m_req_valid, m_req_len, m_req_laddr, m_req_raddr, m_req_last, s_cmd_ready);
            end
            @(posedge aclk);
            #1;
        end
        m_req_ready = 1'b1;
        check_flush("backpressure");
        tests++;
        if (obs_q.size() != 3 || (obs_q.size() == 3 && obs_q[2].cyc !== obs_q[1].cyc + 1)) begin
            fails++;
            $display("FAIL bp_resume: got %0d requests, third chunk not one cycle after the second, required 3 consecutive", obs_q.size());
        end
        clear_q();
    endtask

    task automatic test_back_to_back();
        int acc [4];
        int w;
        m_req_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_cmd(5'h01, 24'(i), 64'h100 * i, 64'h20000 + 64'h100 * i, 32'd100, 24'(20 + i), 1'b1, acc[i], w);
            tests++;
            if (w !== 0 || (i > 0 && acc[i] !== acc[i-1] + 1)) begin
                fails++;
                $display("FAIL b2b_accept%0d: waited %0d cycles, accept cycle %0d, required 0 wait and consecutive", i, w, acc[i]);
            end
        end
        s_cmd_valid = 1'b0;
        check_flush("back_to_back");
        for (int i = 0; i < obs_q.size(); i++) begin
            tests++;
            if (obs_q[i].last !== 1'b1 || obs_q[i].cyc !== obs_q[0].cyc + i) begin
                fails++;
                $display("FAIL b2b_req%0d: last=%b cyc+%0d, required last=1 cyc+%0d", i, obs_q[i].last, obs_q[i].cyc - obs_q[0].cyc, i);
            end
        end
        clear_q();
    endtask

    task automatic test_reset_mid();
        int acc, w;
        m_req_ready = 1'b1;
        send_cmd(5'h0a, 24'h000099, 64'h2000, 64'h1000, 32'd10000, 24'd30, 1'b1, acc, w);
        s_cmd_valid = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b0;
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(negedge aclk);
        tests++;
        if (m_req_valid !== 1'b0 || s_cmd_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_state: m_req_valid=%b s_cmd_ready=%b, required 0 1", m_req_valid, s_cmd_ready);
        end
        repeat (20) @(negedge aclk);
        tests++;
        if (obs_q.size() !== 1 || m_req_valid !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_discard: got %0d requests, m_req_valid=%b, required 1 0", obs_q.size(), m_req_valid);
        end
        clear_q();
    endtask

    task automatic test_random();
        int acc, w;
        logic [31:0] len;
        logic [63:0] la, ra;
        rand_rdy = 1'b1;
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 4))
                0:       len = 32'd0;
                1:       len = 32'(4096 * $urandom_range(1, 4));
                2:       len = 32'($urandom_range(1, 300));
                default: len = 32'($urandom_range(1, 20000));
            endcase
            la = {$urandom, $urandom};
            ra = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 4095))) : {$urandom, $urandom};
            send_cmd(5'($urandom), 24'($urandom), la, ra, len, 24'($urandom), 1'($urandom), acc, w);
            if ($urandom_range(0, 2) == 0) begin
                s_cmd_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge aclk);
                #1;
            end
        end
        s_cmd_valid = 1'b0;
        @(posedge aclk);
        #1;
        rand_rdy = 1'b0;
        m_req_ready = 1'b1;
        check_flush("random");
        clear_q();
    endtask

    initial begin
        test_reset();
        test_split_10000();
        test_exact_and_zero();
`ifdef RDMA_SPLIT_ALIGN_EN
        test_align();
`endif
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
